agc_counter_sequencer: RTL

- Services the AGC involuntary counters: latches per-counter increment (PINC) and decrement (MINC) pulse requests from peripherals.
- Each service steals the single RAM read/write port pair from the Core, stalls the Core, and does a ones-complement read-modify-write on the counter word.
- Sits between Core and agc_ram in the top level and owns the RAM port mux.
- Raises per-counter overflow pulses used later as interrupt sources.

---
 rtl/agc_ctr_pkg.sv | 23 ++
 rtl/ones_comp_incdec.sv | 37 +++
 rtl/agc_counter_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/agc_ctr_pkg.sv
// Shared types and ones-complement constants for the AGC involuntary counter sequencer.
package agc_ctr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        MOD   = 2'd2,
        WRITE = 2'd3
    } ctr_state_t;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } ctr_dir_t;

    localparam logic [14:0] POS_MAX  = 15'o37777;
    localparam logic [14:0] NEG_MAX  = 15'o40000;
    localparam logic [14:0] NEG_ZERO = 15'o77777;

    // Counter index width; covers the full 1..16 counter range.
    localparam int IDX_W = 4;

endpackage

// File: rtl/ones_comp_incdec.sv
// 15-bit ones-complement increment/decrement with overflow detection.
module ones_comp_incdec
    import agc_ctr_pkg::*;
(
    input  logic [14:0] value,
    input  ctr_dir_t    dir,
    output logic [14:0] result,
    output logic        ovf
);

    always_comb begin
        result = value;
        ovf    = 1'b0;
        if (dir == DIR_INC) begin
            if (value == POS_MAX) begin
                result = 15'o00000;
                ovf    = 1'b1;
            end else if (value == NEG_ZERO) begin
                // -0 steps straight to +1, skipping +0
                result = 15'o00001;
            end else begin
                result = value + 15'd1;
            end
        end else begin
            if (value == NEG_MAX) begin
                result = NEG_ZERO;
                ovf    = 1'b1;
            end else if (value == 15'o00000) begin
                // +0 steps straight to -1, skipping -0
                result = 15'o77776;
            end else begin
                result = value - 15'd1;
            end
        end
    end

endmodule

// File: rtl/agc_counter_sequencer.sv
// Services PINC/MINC requests with a stalled read-modify-write on the counter words,
// and owns the RAM port mux between the Core and agc_ram.
module agc_counter_sequencer
    import agc_ctr_pkg::*;
#(
    parameter int          NUM_CTR   = 8,
    parameter logic [10:0] BASE_ADDR = 11'o024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_CTR-1:0] pinc_req,
    input  logic [NUM_CTR-1:0] minc_req,
    input  logic               core_safe,
    input  logic [10:0]        core_ram_read_address,
    input  logic [10:0]        core_ram_write_address,
    input  logic [14:0]        core_ram_write_data,
    input  logic               core_ram_write_en,
    output logic [10:0]        ram_read_address,
    output logic [10:0]        ram_write_address,
    output logic [14:0]        ram_write_data,
    output logic               ram_write_en,
    input  logic [14:0]        ram_read_data,
    output logic               stall,
    output logic [NUM_CTR-1:0] overflow,
    output logic               drop_err
);

    ctr_state_t         state_reg, state_next;
    logic [NUM_CTR-1:0] pend_p_reg, pend_m_reg, pend_p_next, pend_m_next;
    logic [NUM_CTR-1:0] net_p, net_m, net_any, drop_vec;
    logic [IDX_W-1:0]   idx_reg, win_idx;
    logic               win_dec;
    ctr_dir_t           dir_reg;
    logic [14:0]        result_reg, calc_result;
    logic               ovf_reg, calc_ovf;
    logic               drop_err_reg;
    logic               start;
    logic [10:0]        ctr_addr;

    assign net_p   = pend_p_reg & ~pend_m_reg;
    assign net_m   = pend_m_reg & ~pend_p_reg;
    assign net_any = net_p | net_m;
    assign start   = (state_reg == IDLE) && (|net_any) && core_safe;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        win_idx = '0;
        win_dec = 1'b0;
        for (int i = NUM_CTR - 1; i >= 0; i--) begin
            if (net_any[i]) begin
                win_idx = IDX_W'(i);
                win_dec = net_m[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CTR; gi++) begin : g_ctr
            logic req_p, req_m, cancel, take, keep;
            assign req_p  = pinc_req[gi] & ~minc_req[gi];
            assign req_m  = minc_req[gi] & ~pinc_req[gi];
            assign cancel = pend_p_reg[gi] & pend_m_reg[gi];
            assign take   = start && (win_idx == IDX_W'(gi));
            assign keep   = ~cancel & ~take;
            // A new request wins over the clear, so a pulse during service re-pends.
            assign pend_p_next[gi] = (pend_p_reg[gi] & keep) | req_p;
            assign pend_m_next[gi] = (pend_m_reg[gi] & keep) | req_m;
            assign drop_vec[gi]    = (req_p & pend_p_reg[gi] & keep) |
                                     (req_m & pend_m_reg[gi] & keep);
            assign overflow[gi]    = (state_reg == WRITE) && ovf_reg &&
                                     (idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = READ;
            READ:    state_next = MOD;
            MOD:     state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    ones_comp_incdec u_incdec (
        .value  (ram_read_data),
        .dir    (dir_reg),
        .result (calc_result),
        .ovf    (calc_ovf)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            pend_p_reg   <= '0;
            pend_m_reg   <= '0;
            idx_reg      <= '0;
            dir_reg      <= DIR_INC;
            result_reg   <= '0;
            ovf_reg      <= 1'b0;
            drop_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pend_p_reg <= pend_p_next;
            pend_m_reg <= pend_m_next;
            if (|drop_vec)
                drop_err_reg <= 1'b1;
            if (start) begin
                idx_reg <= win_idx;
                dir_reg <= win_dec ? DIR_DEC : DIR_INC;
            end
            if (state_reg == MOD) begin
                result_reg <= calc_result;
                ovf_reg    <= calc_ovf;
            end
        end
    end

    assign ctr_addr          = BASE_ADDR + 11'(idx_reg);
    assign stall             = (state_reg != IDLE);
    assign drop_err          = drop_err_reg;
    assign ram_read_address  = stall ? ctr_addr : core_ram_read_address;
    assign ram_write_address = (state_reg == WRITE) ? ctr_addr : core_ram_write_address;
    assign ram_write_data    = (state_reg == WRITE) ? result_reg : core_ram_write_data;
    assign ram_write_en      = stall ? (state_reg == WRITE) : (core_ram_write_en & ~reset);

endmodule
